// File: rtl/pio_poll_pkg.sv
// Shared definitions for the edge-capture PIO polling master: FSM states,
// PIO register map and the event record handed to the fabric.
package pio_poll_pkg;

  // Widest word a PIO core provides; event fields are held at this width.
  localparam int unsigned PIO_WORD_W = 32;

  // Word addresses inside the PIO slave.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam logic [1:0] PIO_EDGE_ADDR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CAP,
    ST_CAP_WAIT,
    ST_CLR,
    ST_RD_DATA,
    ST_DATA_WAIT,
    ST_EVENT
  } poll_state_e;

  typedef struct packed {
    logic [PIO_WORD_W-1:0] edges;
    logic [PIO_WORD_W-1:0] data;
  } pio_event_t;

endpackage

// File: rtl/poll_interval_timer.sv
// Down-counter that spaces out capture polls. It reloads on 'load',
// counts down while 'enable' is high, and holds at zero once expired.
module poll_interval_timer #(
  parameter int unsigned INTERVAL = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (INTERVAL < 2) ? 1 : $clog2(INTERVAL + 1);
  localparam logic [CW-1:0] RELOAD = CW'(INTERVAL);

  logic [CW-1:0] r_count;

  // Reload has priority over counting; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= RELOAD;
    end else if (load) begin
      r_count <= RELOAD;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/pio_edge_poll_master.sv
// Avalon-MM initiator that polls an edge-capturing PIO slave. A non-zero
// capture word is cleared, the live input word is read, and both are offered
// as one event on a valid/ready stream. Edges that land in the slave between
// the capture read and the clear write (READ_LATENCY+1 cycles) are cleared
// without being reported; that window is accepted behaviour. While an event
// waits for the consumer no polling happens, so the slave keeps
// accumulating edges and nothing is lost to backpressure.
// DATA_WIDTH may be at most 32, the widest PIO word.
module pio_edge_poll_master
  import pio_poll_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [1:0]  CAP_ADDR      = PIO_EDGE_ADDR,
  parameter logic [1:0]  DATA_ADDR     = PIO_DATA_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [1:0]            avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write_n,
  output logic [DATA_WIDTH-1:0] avm_writedata,
  input  logic [DATA_WIDTH-1:0] avm_readdata,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [DATA_WIDTH-1:0] evt_edges,
  output logic [DATA_WIDTH-1:0] evt_data,
  output logic                  busy
);

  // Wait states run from READ_LATENCY-1 down to 0 (latency 1..4).
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  poll_state_e r_state;
  logic [1:0]  r_wait;
  pio_event_t  r_evt;
  logic [1:0]  r_address;
  logic        r_chipselect;
  logic        r_write_n;
  logic        r_evt_valid;
  logic        r_busy;

  logic w_expired;
  logic w_load;
  logic w_countEn;
  logic w_waitDone;
  logic w_readZero;

  assign w_waitDone = (r_wait == 2'd0);
  assign w_readZero = (avm_readdata == '0);
  assign w_load     = (r_state == ST_IDLE) && w_expired && enable;

  // The cycle that hands control back to IDLE already counts as the first
  // idle cycle, so IDLE lasts exactly POLL_INTERVAL cycles between polls.
  assign w_countEn = (r_state == ST_IDLE) ||
                     ((r_state == ST_CAP_WAIT) && w_waitDone && w_readZero) ||
                     ((r_state == ST_EVENT) && evt_ready);

  poll_interval_timer #(
    .INTERVAL(POLL_INTERVAL)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .enable (w_countEn),
    .expired(w_expired)
  );

  // Poll sequencer; bus strobes and stream outputs are registered so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wait       <= 2'd0;
      r_evt        <= '0;
      r_address    <= 2'd0;
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      r_evt_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state      <= ST_RD_CAP;
            r_address    <= CAP_ADDR;
            r_chipselect <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_RD_CAP: begin
          r_state <= ST_CAP_WAIT;
          r_wait  <= LAT_LAST;
        end
        ST_CAP_WAIT: begin
          if (w_waitDone) begin
            r_evt.edges <= PIO_WORD_W'(avm_readdata);
            if (w_readZero) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state      <= ST_CLR;
              r_address    <= CAP_ADDR;
              r_chipselect <= 1'b1;
              r_write_n    <= 1'b0;
            end
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        ST_CLR: begin
          r_state      <= ST_RD_DATA;
          r_address    <= DATA_ADDR;
          r_chipselect <= 1'b1;
        end
        ST_RD_DATA: begin
          r_state <= ST_DATA_WAIT;
          r_wait  <= LAT_LAST;
        end
        ST_DATA_WAIT: begin
          if (w_waitDone) begin
            r_evt.data  <= PIO_WORD_W'(avm_readdata);
            r_state     <= ST_EVENT;
            r_evt_valid <= 1'b1;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        ST_EVENT: begin
          if (evt_ready) begin
            r_state     <= ST_IDLE;
            r_evt_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_evt_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address    = r_address;
  assign avm_chipselect = r_chipselect;
  assign avm_write_n    = r_write_n;
  assign avm_writedata  = '0;
  assign evt_valid      = r_evt_valid;
  assign evt_edges      = r_evt.edges[DATA_WIDTH-1:0];
  assign evt_data       = r_evt.data[DATA_WIDTH-1:0];
  assign busy           = r_busy;

endmodule
